// File: rtl/mips_pipe_pkg.sv
// Shared constants for the MIPS front-end: NOP encoding, default reset PC,
// fetch FSM encoding and the IF/ID register layout.
package mips_pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: 32'h0, valid: 1'b0};

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_ifid_ctrl.sv
// PC register, IF/ID register and instruction-memory address generation,
// with redirect/stall/flush handling, a stall watchdog and debug counters.
module fetch_ifid_ctrl
  import mips_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_W     = 16,
  parameter int          STALL_MAX = 64
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             NotStall_PC,
  input  logic             NotStall_IFID,
  input  logic             Flush_ID,
  input  logic             JumpTaken_EX,
  input  logic [31:0]      JumpTarget_EX,
  input  logic             Branch_MEM,
  input  logic [31:0]      BranchTarget_MEM,
  output logic [31:0]      IMem_Addr,
  input  logic [31:0]      IMem_RdData,
  output logic [31:0]      PC_IF,
  output logic [31:0]      Instruction_ID,
  output logic [31:0]      PCPlus4_ID,
  output logic             Valid_ID,
  output logic             Stall_Timeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  localparam int                RUN_W       = $clog2(STALL_MAX + 1);
  localparam logic [RUN_W-1:0] STALL_MAX_R = RUN_W'(STALL_MAX);

  logic             stall;
  logic             redirect;
  logic             flush_evt;
  logic             stall_evt;
  logic [31:0]      pc_reg;
  logic [31:0]      pc_next;
  logic [31:0]      pc_plus4;
  ifid_t            ifid_reg;
  ifid_t            ifid_next;
  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [RUN_W-1:0] run_cnt_reg;
  logic [RUN_W-1:0] run_cnt_next;
  logic             timeout_reg;
  logic             timeout_next;

  // Either stall input freezes the whole front end; redirects win over both.
  assign stall     = !NotStall_PC || !NotStall_IFID;
  assign redirect  = Branch_MEM || JumpTaken_EX;
  assign flush_evt = Flush_ID || redirect;
  assign stall_evt = stall && !redirect;
  assign pc_plus4  = pc_reg + 32'd4;

  always_comb begin
    pc_next = pc_plus4;
    if (Branch_MEM) begin
      pc_next = BranchTarget_MEM;
    end else if (JumpTaken_EX) begin
      pc_next = JumpTarget_EX;
    end else if (stall) begin
      pc_next = pc_reg;
    end
  end

  // The ROM registers this address, so its data lines up with PC_IF next cycle.
  assign IMem_Addr = pc_next;

  always_comb begin
    ifid_next = ifid_reg;
    if (state_reg == ST_BOOT || flush_evt) begin
      ifid_next = IFID_BUBBLE;
    end else if (!NotStall_IFID) begin
      ifid_next = ifid_reg;
    end else if (!NotStall_PC) begin
      // PC is frozen, so loading now would present the same word twice.
      ifid_next = IFID_BUBBLE;
    end else begin
      ifid_next = '{instr: IMem_RdData, pc_plus4: pc_plus4, valid: 1'b1};
    end
  end

  always_comb begin
    state_next   = state_reg;
    run_cnt_next = run_cnt_reg;
    timeout_next = timeout_reg;
    case (state_reg)
      ST_BOOT: state_next = ST_RUN;
      ST_RUN: begin
        if (stall_evt) begin
          state_next   = ST_STALL;
          run_cnt_next = RUN_W'(1);
        end
      end
      ST_STALL: begin
        if (stall_evt) begin
          if (run_cnt_reg != STALL_MAX_R) begin
            run_cnt_next = run_cnt_reg + RUN_W'(1);
          end
        end else begin
          state_next   = ST_RUN;
          run_cnt_next = '0;
        end
      end
      default: begin
        state_next   = ST_RUN;
        run_cnt_next = '0;
      end
    endcase
    if (run_cnt_next == STALL_MAX_R) begin
      timeout_next = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_reg      <= RESET_PC;
      ifid_reg    <= IFID_BUBBLE;
      state_reg   <= ST_BOOT;
      run_cnt_reg <= '0;
      timeout_reg <= 1'b0;
    end else begin
      pc_reg      <= pc_next;
      ifid_reg    <= ifid_next;
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      timeout_reg <= timeout_next;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (Clk),
    .clr_n (Reset_n),
    .inc   (stall_evt),
    .count (StallCount)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (Clk),
    .clr_n (Reset_n),
    .inc   (flush_evt),
    .count (FlushCount)
  );

  assign PC_IF          = pc_reg;
  assign Instruction_ID = ifid_reg.instr;
  assign PCPlus4_ID     = ifid_reg.pc_plus4;
  assign Valid_ID       = ifid_reg.valid;
  assign Stall_Timeout  = timeout_reg;

endmodule

// File: tb/tb_fetch_ifid_ctrl.sv
// Directed bench for fetch_ifid_ctrl: vector table for the per-cycle behaviour,
// hand-written sequences for the watchdog and asynchronous reset.
module tb_fetch_ifid_ctrl;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        NotStall_PC, NotStall_IFID, Flush_ID;
  logic        JumpTaken_EX, Branch_MEM;
  logic [31:0] JumpTarget_EX, BranchTarget_MEM;
  logic [31:0] IMem_Addr, IMem_RdData;
  logic [31:0] PC_IF, Instruction_ID, PCPlus4_ID;
  logic        Valid_ID, Stall_Timeout;
  logic [15:0] StallCount, FlushCount;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_ifid_ctrl #(.RESET_PC(32'h0), .CNT_W(16), .STALL_MAX(64)) dut (
    .Clk              (Clk),
    .Reset_n          (Reset_n),
    .NotStall_PC      (NotStall_PC),
    .NotStall_IFID    (NotStall_IFID),
    .Flush_ID         (Flush_ID),
    .JumpTaken_EX     (JumpTaken_EX),
    .JumpTarget_EX    (JumpTarget_EX),
    .Branch_MEM       (Branch_MEM),
    .BranchTarget_MEM (BranchTarget_MEM),
    .IMem_Addr        (IMem_Addr),
    .IMem_RdData      (IMem_RdData),
    .PC_IF            (PC_IF),
    .Instruction_ID   (Instruction_ID),
    .PCPlus4_ID       (PCPlus4_ID),
    .Valid_ID         (Valid_ID),
    .Stall_Timeout    (Stall_Timeout),
    .StallCount       (StallCount),
    .FlushCount       (FlushCount)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM: word content is its address XOR a fixed tag.
  always @(posedge Clk) IMem_RdData <= IMem_Addr ^ 32'hA5A5_0000;

  typedef struct {
    logic        ns_pc, ns_ifid, flush, jt;
    logic [31:0] jtgt;
    logic        br;
    logic [31:0] btgt;
    logic [31:0] e_pc, e_instr, e_p4;
    logic        e_valid;
    logic [15:0] e_sc, e_fc;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic ns_pc, logic ns_ifid, logic flush, logic jt,
                              logic [31:0] jtgt, logic br, logic [31:0] btgt,
                              logic [31:0] e_pc, logic [31:0] e_instr, logic [31:0] e_p4,
                              logic e_valid, logic [15:0] e_sc, logic [15:0] e_fc);
    vec_t v;
    v.ns_pc = ns_pc; v.ns_ifid = ns_ifid; v.flush = flush; v.jt = jt; v.jtgt = jtgt;
    v.br = br; v.btgt = btgt; v.e_pc = e_pc; v.e_instr = e_instr; v.e_p4 = e_p4;
    v.e_valid = e_valid; v.e_sc = e_sc; v.e_fc = e_fc;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ns_pc, input logic ns_ifid, input logic flush,
                       input logic jt, input logic [31:0] jtgt,
                       input logic br, input logic [31:0] btgt);
    NotStall_PC = ns_pc; NotStall_IFID = ns_ifid; Flush_ID = flush;
    JumpTaken_EX = jt; JumpTarget_EX = jtgt; Branch_MEM = br; BranchTarget_MEM = btgt;
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " pc"},      PC_IF,          32'h0);
    check({tag, " instr"},   Instruction_ID, 32'h0);
    check({tag, " p4"},      PCPlus4_ID,     32'h0);
    check({tag, " valid"},   {31'b0, Valid_ID},      32'h0);
    check({tag, " timeout"}, {31'b0, Stall_Timeout}, 32'h0);
    check({tag, " stallcnt"}, {16'b0, StallCount},   32'h0);
    check({tag, " flushcnt"}, {16'b0, FlushCount},   32'h0);
    check({tag, " imem"},    IMem_Addr,      32'h4);
  endtask

  initial begin
    //               nsPC nsID fl jt jtgt          br btgt       pc            instr         p4            v  sc  fc
    vecs[0]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h4,        32'h0,        32'h0,        0, 0, 0);
    vecs[1]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h8,        32'hA5A50004, 32'h8,        1, 0, 0);
    vecs[2]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'hC,        32'hA5A50008, 32'hC,        1, 0, 0);
    vecs[3]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h10,       32'hA5A5000C, 32'h10,       1, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,   32'h10,       32'hA5A5000C, 32'h10,       1, 1, 0);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,   32'h10,       32'hA5A5000C, 32'h10,       1, 2, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,   32'h10,       32'hA5A5000C, 32'h10,       1, 3, 0);
    vecs[7]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h14,       32'hA5A50010, 32'h14,       1, 3, 0);
    vecs[8]  = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h18,       32'hA5A50014, 32'h18,       1, 3, 0);
    vecs[9]  = mk(1, 1, 0, 1, 32'h200,       1, 32'h100, 32'h100,      32'h0,        32'h0,        0, 3, 1);
    vecs[10] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h104,      32'hA5A50100, 32'h104,      1, 3, 1);
    vecs[11] = mk(0, 0, 0, 1, 32'h40,        0, 32'h0,   32'h40,       32'h0,        32'h0,        0, 3, 2);
    vecs[12] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h44,       32'hA5A50040, 32'h44,       1, 3, 2);
    vecs[13] = mk(0, 1, 0, 0, 32'h0,         0, 32'h0,   32'h44,       32'h0,        32'h0,        0, 4, 2);
    vecs[14] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h48,       32'hA5A50044, 32'h48,       1, 4, 2);
    vecs[15] = mk(1, 1, 1, 0, 32'h0,         0, 32'h0,   32'h4C,       32'h0,        32'h0,        0, 4, 3);
    vecs[16] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h50,       32'hA5A5004C, 32'h50,       1, 4, 3);
    vecs[17] = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,   32'h50,       32'hA5A5004C, 32'h50,       1, 5, 3);
    vecs[18] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h54,       32'hA5A50050, 32'h54,       1, 5, 3);
    vecs[19] = mk(1, 1, 0, 1, 32'hFFFFFFFC,  0, 32'h0,   32'hFFFFFFFC, 32'h0,        32'h0,        0, 5, 4);
    vecs[20] = mk(1, 1, 0, 0, 32'h0,         0, 32'h0,   32'h0,        32'h5A5AFFFC, 32'h0,        1, 5, 4);

    Reset_n = 1'b0;
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    step();
    step();
    check_reset_state("reset");

    Reset_n = 1'b1;
    for (int i = 0; i < 21; i++) begin
      drive(vecs[i].ns_pc, vecs[i].ns_ifid, vecs[i].flush, vecs[i].jt, vecs[i].jtgt,
            vecs[i].br, vecs[i].btgt);
      #1;
      check($sformatf("v%0d imem", i), IMem_Addr, vecs[i].e_pc);
      step();
      check($sformatf("v%0d pc", i),       PC_IF,          vecs[i].e_pc);
      check($sformatf("v%0d instr", i),    Instruction_ID, vecs[i].e_instr);
      check($sformatf("v%0d p4", i),       PCPlus4_ID,     vecs[i].e_p4);
      check($sformatf("v%0d valid", i),    {31'b0, Valid_ID},   {31'b0, vecs[i].e_valid});
      check($sformatf("v%0d stallcnt", i), {16'b0, StallCount}, {16'b0, vecs[i].e_sc});
      check($sformatf("v%0d flushcnt", i), {16'b0, FlushCount}, {16'b0, vecs[i].e_fc});
      $display("vec %0d: pc=%h instr=%h p4=%h valid=%0d sc=%0d fc=%0d",
               i, PC_IF, Instruction_ID, PCPlus4_ID, Valid_ID, StallCount, FlushCount);
    end

    // Watchdog: 64 consecutive stall cycles from RUN at PC=0.
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    for (int i = 1; i <= 64; i++) begin
      step();
      if (i == 63) check("timeout after 63", {31'b0, Stall_Timeout}, 32'h0);
      if (i == 64) check("timeout after 64", {31'b0, Stall_Timeout}, 32'h1);
    end
    $display("stall run: pc=%h sc=%0d timeout=%0d", PC_IF, StallCount, Stall_Timeout);
    check("stall run pc held", PC_IF, 32'h0);
    drive(1, 1, 0, 0, 32'h0, 0, 32'h0);
    step();
    check("timeout sticky",      {31'b0, Stall_Timeout}, 32'h1);
    check("pc after long stall", PC_IF, 32'h4);
    check("stallcnt after run",  {16'b0, StallCount}, 32'd69);
    $display("release: pc=%h sc=%0d timeout=%0d", PC_IF, StallCount, Stall_Timeout);

    // Asynchronous reset pulse between clock edges.
    step();
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_state("async reset");
    $display("async reset: pc=%h valid=%0d timeout=%0d", PC_IF, Valid_ID, Stall_Timeout);
    step();
    Reset_n = 1'b1;
    step();
    check("boot pc",    PC_IF, 32'h4);
    check("boot valid", {31'b0, Valid_ID}, 32'h0);
    step();
    check("post-boot instr", Instruction_ID, 32'hA5A50004);
    check("post-boot valid", {31'b0, Valid_ID}, 32'h1);
    $display("post-boot: pc=%h instr=%h valid=%0d", PC_IF, Instruction_ID, Valid_ID);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ifid_ctrl.md
Name: fetch_ifid_ctrl

Overview:
- Consumer of the hazard unit's stall/flush outputs at the front of the 5-stage MIPS pipeline.
- Owns the PC register, the IF/ID pipeline register and the instruction-memory address.
- Applies redirects from taken jumps (EX) and taken branches (MEM), holds state on stall, and inserts NOP bubbles on flush.
- Adds a stall-duration watchdog and saturating stall/flush event counters for debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded at reset
CNT_W, 16, width of each event counter
STALL_MAX, 64, consecutive stall cycles before Stall_Timeout sets

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
NotStall_PC  in  1  1 = PC may advance
NotStall_IFID  in  1  1 = IF/ID may load
Flush_ID  in  1  1 = IF/ID loads a bubble
JumpTaken_EX  in  1  j/jal/jr resolved in EX
JumpTarget_EX  in  32  jump target
Branch_MEM  in  1  taken branch resolved in MEM
BranchTarget_MEM  in  32  branch target
IMem_Addr  out  32  synchronous ROM address (combinational next-PC)
IMem_RdData  in  32  ROM data, 1-cycle latency, equals mem[PC] in the current cycle
PC_IF  out  32  current PC
Instruction_ID  out  32  IF/ID instruction
PCPlus4_ID  out  32  IF/ID PC+4
Valid_ID  out  1  IF/ID holds a real instruction
Stall_Timeout  out  1  sticky watchdog flag
StallCount  out  CNT_W  saturating stall-cycle count
FlushCount  out  CNT_W  saturating flush-event count

Behaviour:
- Reset, async on Reset_n=0:
  - PC_IF=RESET_PC; Instruction_ID=0 (NOP); PCPlus4_ID=0; Valid_ID=0.
  - Counters=0; Stall_Timeout=0; FSM=BOOT.
- Next-PC priority, highest first:
  1. Branch_MEM → BranchTarget_MEM.
  2. JumpTaken_EX → JumpTarget_EX.
  3. Stall (NotStall_PC=0 or NotStall_IFID=0) → PC_IF.
  4. Otherwise → PC_IF+4, 32-bit wrap.
- Branch_MEM beats JumpTaken_EX because MEM is the older instruction.
- A redirect overrides a stall.
- IMem_Addr = next-PC, so ROM data aligns with PC_IF one cycle later. No extra redirect latency.
- IF/ID update, highest priority first:
  1. Flush_ID, Branch_MEM or JumpTaken_EX → bubble: Instruction_ID=0, Valid_ID=0, PCPlus4_ID=0.
  2. NotStall_IFID=0 → hold.
  3. NotStall_IFID=1 and NotStall_PC=0 → bubble, to prevent a duplicate fetch.
  4. Otherwise load: IMem_RdData, PC_IF+4, Valid_ID=1.
- NotStall_PC=1 with NotStall_IFID=0 is treated as a full stall; PC is held.
- FSM states: BOOT, RUN, STALL.
  - BOOT: the single cycle after reset release. ROM output is not yet valid, so IF/ID loads a bubble. The PC still advances: next-PC for PC_IF=RESET_PC. Always → RUN.
  - RUN: on stall with no redirect → STALL and load the stall-run counter with 1. Otherwise stay.
  - STALL: each further stall cycle increments the run counter. At run counter == STALL_MAX, set Stall_Timeout; it stays set until reset. A non-stall cycle or any redirect → RUN and clears the run counter.
- StallCount: +1 on every cycle with stall and no redirect, saturating at all-ones.
- FlushCount: +1 on every cycle where IF/ID loads a bubble due to Flush_ID or a redirect, saturating. BOOT bubbles do not count.
- Reset mid-operation: all state returns to reset values immediately. The first edge after release executes BOOT.

Decomposition:
- Shared package mips_pipe_pkg:
  - NOP_INSTR=32'h0
  - RESET_PC default
  - FSM state encoding: BOOT=2'd0, RUN=2'd1, STALL=2'd2
- One sub-module: sat_counter (parameter W; inc input; async active-low clear), instantiated twice for StallCount and FlushCount.
- The remaining logic lives in fetch_ifid_ctrl.

Test Plan:
1. Reset release with no stalls: first cycle Valid_ID=0. PC_IF sequence is 0,4,8,C. Instruction_ID follows ROM words one cycle behind the PC, with Valid_ID=1 from the 2nd edge.
2. Stall for 3 cycles at PC=0x10 (NotStall_PC=NotStall_IFID=0): PC_IF and IF/ID held constant, StallCount=3. On release PC_IF=0x14 and no instruction is duplicated or skipped.
3. Branch_MEM=1 to 0x100 and JumpTaken_EX=1 to 0x200 in the same cycle: next PC_IF=0x100, IF/ID bubble, FlushCount=1.
4. Jump to 0x40 while a stall is asserted: PC_IF=0x40 next cycle, Valid_ID=0, StallCount unchanged.
5. NotStall_PC=0 with NotStall_IFID=1: PC held, Valid_ID=0 next cycle, no repeated instruction.
6. Stall held for 64 cycles: Stall_Timeout=1 after the 64th stall cycle and remains 1 after the stall clears. Reset_n pulse mid-run returns every output to its reset value asynchronously.
